// File: rtl/pe_stream_arbiter_if.sv
// Request/grant/finish bundle between NUM_PE processing elements, the stream engine and the arbiter.
// master = PE/stream-engine side, slave = arbiter side.
interface pe_stream_arbiter_if #(
    parameter int NUM_PE = 4
);
    localparam int IDW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [NUM_PE-1:0] req_input;
    logic [NUM_PE-1:0] req_filter;
    logic              stream_done;
    logic              stream_start;
    logic [NUM_PE-1:0] grant_onehot;
    logic [IDW-1:0]    grant_id;
    logic              grant_is_filter;
    logic [NUM_PE-1:0] Stream_input_finish_PE;
    logic [NUM_PE-1:0] Stream_filter_finish;
    logic              busy;

    modport master (
        output req_input, req_filter, stream_done,
        input  stream_start, grant_onehot, grant_id, grant_is_filter,
        input  Stream_input_finish_PE, Stream_filter_finish, busy
    );

    modport slave (
        input  req_input, req_filter, stream_done,
        output stream_start, grant_onehot, grant_id, grant_is_filter,
        output Stream_input_finish_PE, Stream_filter_finish, busy
    );
endinterface

// File: rtl/pe_stream_arbiter.sv
// Round-robin arbiter sharing one stream engine among NUM_PE PEs (IDLE/GRANT/STREAM/FINISH).
// Request->start 1 cycle, done->finish 1 cycle; PE_FILTER_BROADCAST_EN enables filter broadcast.
module pe_stream_arbiter #(
    parameter int NUM_PE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_stream_arbiter_if.slave   bus
);
    localparam int IDW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, FINISH} state_t;

    state_t            state_q, state_d;
    logic              stream_start_q, stream_start_d;
    logic [NUM_PE-1:0] grant_onehot_q, grant_onehot_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              grant_is_filter_q, grant_is_filter_d;
    logic [NUM_PE-1:0] fin_in_q, fin_in_d;
    logic [NUM_PE-1:0] fin_flt_q, fin_flt_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_PE-1:0] mask_in_q, mask_in_d;
    logic [NUM_PE-1:0] mask_flt_q, mask_flt_d;
    logic [NUM_PE-1:0] flt_set;

    logic [NUM_PE-1:0] eff_in, eff_flt;
    logic              win_found, win_flt;
    logic [IDW-1:0]    win_id, cand;

`ifdef PE_FILTER_BROADCAST_EN
    logic [NUM_PE-1:0] bcast_q, bcast_d;

    // The granted PE is always part of its own broadcast, even if it dropped its request.
    assign flt_set = bcast_q | grant_onehot_q;
`else
    assign flt_set = grant_onehot_q;
`endif

    // Upward search from rr_ptr with wrap; input beats filter inside the winning PE.
    always_comb begin
        eff_in    = bus.req_input  & ~mask_in_q;
        eff_flt   = bus.req_filter & ~mask_flt_q;
        win_found = 1'b0;
        win_id    = '0;
        win_flt   = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NUM_PE);
            if (!win_found && (eff_in[cand] || eff_flt[cand])) begin
                win_found = 1'b1;
                win_id    = cand;
                win_flt   = !eff_in[cand];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        stream_start_d    = 1'b0;
        grant_onehot_d    = grant_onehot_q;
        grant_id_d        = grant_id_q;
        grant_is_filter_d = grant_is_filter_q;
        fin_in_d          = '0;
        fin_flt_d         = '0;
        rr_ptr_d          = rr_ptr_q;
        mask_in_d         = '0;
        mask_flt_d        = '0;
`ifdef PE_FILTER_BROADCAST_EN
        bcast_d           = bcast_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d           = GRANT;
                    stream_start_d    = 1'b1;
                    grant_onehot_d    = NUM_PE'(1) << win_id;
                    grant_id_d        = win_id;
                    grant_is_filter_d = win_flt;
                end
            end
            GRANT: begin
                state_d = STREAM;
`ifdef PE_FILTER_BROADCAST_EN
                bcast_d = grant_is_filter_q ? bus.req_filter : '0;
`endif
            end
            STREAM: begin
                if (bus.stream_done) begin
                    state_d = FINISH;
                    if (grant_is_filter_q) fin_flt_d = flt_set;
                    else                   fin_in_d  = grant_onehot_q;
                end
            end
            FINISH: begin
                state_d           = IDLE;
                grant_onehot_d    = '0;
                grant_id_d        = '0;
                grant_is_filter_d = 1'b0;
                rr_ptr_d          = (grant_id_q == IDW'(NUM_PE - 1)) ? '0 : grant_id_q + IDW'(1);
                // Served requests sit out the next IDLE cycle while the PE drops them.
                mask_in_d         = grant_is_filter_q ? '0 : grant_onehot_q;
                mask_flt_d        = grant_is_filter_q ? flt_set : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            stream_start_q    <= 1'b0;
            grant_onehot_q    <= '0;
            grant_id_q        <= '0;
            grant_is_filter_q <= 1'b0;
            fin_in_q          <= '0;
            fin_flt_q         <= '0;
            rr_ptr_q          <= '0;
            mask_in_q         <= '0;
            mask_flt_q        <= '0;
`ifdef PE_FILTER_BROADCAST_EN
            bcast_q           <= '0;
`endif
        end else begin
            state_q           <= state_d;
            stream_start_q    <= stream_start_d;
            grant_onehot_q    <= grant_onehot_d;
            grant_id_q        <= grant_id_d;
            grant_is_filter_q <= grant_is_filter_d;
            fin_in_q          <= fin_in_d;
            fin_flt_q         <= fin_flt_d;
            rr_ptr_q          <= rr_ptr_d;
            mask_in_q         <= mask_in_d;
            mask_flt_q        <= mask_flt_d;
`ifdef PE_FILTER_BROADCAST_EN
            bcast_q           <= bcast_d;
`endif
        end
    end

    assign bus.stream_start           = stream_start_q;
    assign bus.grant_onehot           = grant_onehot_q;
    assign bus.grant_id               = grant_id_q;
    assign bus.grant_is_filter        = grant_is_filter_q;
    assign bus.Stream_input_finish_PE = fin_in_q;
    assign bus.Stream_filter_finish   = fin_flt_q;
    assign bus.busy                   = (state_q != IDLE);
endmodule

// File: tb/tb_pe_stream_arbiter.sv
// Randomized bench for pe_stream_arbiter: PE/engine agents, a timestamp-based reference model
// and a negedge monitor that pops expected start/finish events from scoreboard queues.
module tb_pe_stream_arbiter;
    localparam int N     = 4;
    localparam int NCYC  = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_stream_arbiter_if #(.NUM_PE(N)) bus ();
    pe_stream_arbiter #(.NUM_PE(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { int cyc; int id; bit flt; } gexp_t;
    typedef struct { int cyc; logic [N-1:0] vec; bit flt; } fexp_t;
    gexp_t gq[$];
    fexp_t fq[$];

    int vecs = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: owner plus timestamps of its grant and finish.
    bit         m_own;
    int         m_id, m_start, m_fin, m_rr, m_mask_cyc;
    bit         m_flt;
    logic [N-1:0] m_mask_in, m_mask_flt, m_bset;
    logic         e_busy;
    logic [N-1:0] e_oh;

    // PE and stream-engine agents.
    logic [N-1:0] pend_in, pend_flt, wd_in, wd_flt;
    int           drop_in_at[N], drop_flt_at[N];
    int           n_rst = 0;
    logic [N-1:0] p_in, p_flt;
    logic         p_rst, p_done, done_v;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model to cycle c using the inputs that were driven during cycle c-1.
    task automatic model_step(input int c);
        bit           found, mk, in_ok, f_ok;
        int           p;
        logic [N-1:0] vec;
        found = 1'b0;
        if (p_rst) begin
            m_own = 1'b0; m_rr = 0; m_mask_cyc = -1; m_fin = -1;
        end else if (!m_own) begin
            mk = (m_mask_cyc == c - 1);
            for (int k = 0; k < N; k++) begin
                p     = (m_rr + k) % N;
                in_ok = p_in[p]  && !(mk && m_mask_in[p]);
                f_ok  = p_flt[p] && !(mk && m_mask_flt[p]);
                if (!found && (in_ok || f_ok)) begin
                    found = 1'b1; m_id = p; m_flt = !in_ok;
                end
            end
            if (found) begin
                m_own = 1'b1; m_start = c; m_fin = -1; m_bset = '0;
                gq.push_back('{c, m_id, m_flt});
            end
        end else if (m_fin == c - 1) begin
            m_own = 1'b0;
        end else if (c - 1 == m_start) begin
`ifdef PE_FILTER_BROADCAST_EN
            if (m_flt) m_bset = p_flt;
`endif
        end else if (m_fin < 0 && p_done) begin
            m_fin = c;
            vec   = onehot(m_id) | (m_flt ? m_bset : {N{1'b0}});
            fq.push_back('{c, vec, m_flt});
            m_rr       = (m_id + 1) % N;
            m_mask_cyc = c + 1;
            m_mask_in  = m_flt ? {N{1'b0}} : vec;
            m_mask_flt = m_flt ? vec : {N{1'b0}};
            for (int q = 0; q < N; q++) begin
                if (vec[q]) begin
                    if (m_flt) drop_flt_at[q] = c + 1 + int'($urandom_range(0, 1));
                    else       drop_in_at[q]  = c + 1 + int'($urandom_range(0, 1));
                end
            end
        end
        e_busy = m_own;
        e_oh   = m_own ? onehot(m_id) : {N{1'b0}};
    endtask

    // Choose the inputs held during cycle c.
    task automatic drive(input int c);
        if (c <= 3) begin
            rst = 1'b1;
        end else if (c > 200 && n_rst < 6 && m_own && m_fin < 0 && c > m_start + 1
                     && $urandom_range(0, 39) == 0) begin
            rst = 1'b1; n_rst++; wd_in = '0; wd_flt = '0;
        end else begin
            rst = 1'b0;
        end
        for (int q = 0; q < N; q++) begin
            if (drop_in_at[q] == c)  begin pend_in[q]  = 1'b0; wd_in[q]  = 1'b0; drop_in_at[q]  = -1; end
            if (drop_flt_at[q] == c) begin pend_flt[q] = 1'b0; wd_flt[q] = 1'b0; drop_flt_at[q] = -1; end
        end
        if (c == 4) pend_in = '1;
        if (c >= 120) begin
            for (int q = 0; q < N; q++) begin
                if (!pend_in[q]  && drop_in_at[q]  < 0 && $urandom_range(0, 7) == 0) pend_in[q]  = 1'b1;
                if (!pend_flt[q] && drop_flt_at[q] < 0 && $urandom_range(0, 9) == 0) pend_flt[q] = 1'b1;
            end
            if (m_own && m_fin < 0 && c > m_start && $urandom_range(0, 11) == 0) begin
                if (m_flt) wd_flt[m_id] = 1'b1;
                else       wd_in[m_id]  = 1'b1;
            end
        end
        // Done pulses outside the streaming window exercise the ignore rule.
        if (m_own && m_fin < 0 && c > m_start) done_v = ($urandom_range(0, 2) == 0);
        else                                   done_v = ($urandom_range(0, 5) == 0);
        bus.req_input   = pend_in & ~wd_in;
        bus.req_filter  = pend_flt & ~wd_flt;
        bus.stream_done = done_v;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_input = '0; bus.req_filter = '0; bus.stream_done = 1'b0;
        pend_in = '0; pend_flt = '0; wd_in = '0; wd_flt = '0;
        for (int q = 0; q < N; q++) begin drop_in_at[q] = -1; drop_flt_at[q] = -1; end
        m_own = 1'b0; m_id = 0; m_flt = 1'b0; m_start = -1; m_fin = -1; m_rr = 0; m_mask_cyc = -1;
        m_mask_in = '0; m_mask_flt = '0; m_bset = '0; e_busy = 1'b0; e_oh = '0;
        repeat (NCYC) begin
            @(posedge clk);
            #1;
            cyc++;
            p_rst  = rst;
            p_in   = bus.req_input;
            p_flt  = bus.req_filter;
            p_done = bus.stream_done;
            model_step(cyc);
            drive(cyc);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        gexp_t g;
        fexp_t f;
        bit    exp_s, exp_f;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("busy", bus.busy, e_busy);
                chk("grant_onehot", bus.grant_onehot, e_oh);
                while (gq.size() > 0 && gq[0].cyc < cyc) void'(gq.pop_front());
                while (fq.size() > 0 && fq[0].cyc < cyc) void'(fq.pop_front());
                exp_s = (gq.size() > 0 && gq[0].cyc == cyc);
                chk("stream_start", bus.stream_start, exp_s);
                if (exp_s) begin
                    g = gq.pop_front();
                    chk("grant_id", bus.grant_id, g.id);
                    chk("grant_is_filter", bus.grant_is_filter, g.flt);
                end else if (!e_busy) begin
                    chk("idle_grant_id", bus.grant_id, 0);
                    chk("idle_is_filter", bus.grant_is_filter, 0);
                end
                exp_f = (fq.size() > 0 && fq[0].cyc == cyc);
                chk("finish_pulse", |(bus.Stream_input_finish_PE | bus.Stream_filter_finish), exp_f);
                if (exp_f) begin
                    f = fq.pop_front();
                    chk("input_finish_vec", bus.Stream_input_finish_PE, f.flt ? {N{1'b0}} : f.vec);
                    chk("filter_finish_vec", bus.Stream_filter_finish, f.flt ? f.vec : {N{1'b0}});
                end
            end
        end
    end
endmodule
